// File: rtl/dm_arbiter.sv
// Round-robin arbiter sharing one word-wide data memory between two requesters,
// with alignment/range checking and read-modify-write for byte/halfword stores.

// state  | meaning
// IDLE   | sample requests, pick winner, latch fields, check for errors
// ACCESS | word read, or word write; sub-word store reads the old word
// MERGE  | write back the old word with the target lane replaced
// RESP   | one-cycle ack to the owner with rdata/err
module dm_arbiter #(
    parameter int MEM_BYTES = 12288,
    parameter int ADDR_W    = 14
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              p0_req,
    input  logic              p0_we,
    input  logic [1:0]        p0_size,
    input  logic [ADDR_W-1:0] p0_addr,
    input  logic [31:0]       p0_wdata,
    output logic              p0_ack,
    output logic [31:0]       p0_rdata,
    output logic              p0_err,
    input  logic              p1_req,
    input  logic              p1_we,
    input  logic [1:0]        p1_size,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic [31:0]       p1_wdata,
    output logic              p1_ack,
    output logic [31:0]       p1_rdata,
    output logic              p1_err,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_din,
    output logic              mem_we,
    input  logic [31:0]       mem_dout
);

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_BAD  = 2'b11;
    localparam logic [ADDR_W-1:0] LAST_WORD = ADDR_W'(MEM_BYTES - 4);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        MERGE  = 2'd2,
        RESP   = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic                last_q, last_d;
    logic                owner_q, owner_d;
    logic                we_q, we_d;
    logic [1:0]          size_q, size_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [31:0]         wdata_q, wdata_d;
    logic                err_q, err_d;
    logic [31:0]         merge_q, merge_d;
    logic [31:0]         rdata0_q, rdata0_d;
    logic [31:0]         rdata1_q, rdata1_d;

    logic                winner;
    logic                sel_we;
    logic [1:0]          sel_size;
    logic [ADDR_W-1:0]   sel_addr;
    logic [31:0]         sel_wdata;
    logic                sel_err;
    logic                upd_rdata;
    logic [31:0]         upd_val;

    // Right-justify the addressed lane; halfwords are 2-aligned so lo*8 picks addr[1].
    function automatic logic [31:0] lane_extract(input logic [31:0] word,
                                                 input logic [1:0]  size,
                                                 input logic [1:0]  lo);
        logic [31:0] shifted;
        shifted = word >> {lo, 3'b000};
        case (size)
            SZ_BYTE: lane_extract = {24'h0, shifted[7:0]};
            SZ_HALF: lane_extract = {16'h0, shifted[15:0]};
            default: lane_extract = word;
        endcase
    endfunction

    function automatic logic [31:0] lane_merge(input logic [31:0] word,
                                               input logic [1:0]  size,
                                               input logic [1:0]  lo,
                                               input logic [31:0] wdata);
        logic [31:0] mask;
        mask = (size == SZ_BYTE) ? 32'h0000_00FF : 32'h0000_FFFF;
        mask = mask << {lo, 3'b000};
        lane_merge = (word & ~mask) | ((wdata << {lo, 3'b000}) & mask);
    endfunction

    // On a tie the port that did not win last time is granted.
    always_comb begin
        winner = 1'b0;
        if (p0_req && p1_req) begin
            winner = ~last_q;
        end else if (p1_req) begin
            winner = 1'b1;
        end
    end

    assign sel_we    = winner ? p1_we    : p0_we;
    assign sel_size  = winner ? p1_size  : p0_size;
    assign sel_addr  = winner ? p1_addr  : p0_addr;
    assign sel_wdata = winner ? p1_wdata : p0_wdata;

    assign sel_err = (sel_size == SZ_BAD)
                   | ((sel_size == SZ_HALF) && sel_addr[0])
                   | ((sel_size == SZ_WORD) && (sel_addr[1:0] != 2'b00))
                   | ({sel_addr[ADDR_W-1:2], 2'b00} > LAST_WORD);

    always_comb begin
        state_d   = state_q;
        last_d    = last_q;
        owner_d   = owner_q;
        we_d      = we_q;
        size_d    = size_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        err_d     = err_q;
        merge_d   = merge_q;
        rdata0_d  = rdata0_q;
        rdata1_d  = rdata1_q;
        upd_rdata = 1'b0;
        upd_val   = 32'h0;

        case (state_q)
            IDLE: begin
                if (p0_req || p1_req) begin
                    last_d  = winner;
                    owner_d = winner;
                    we_d    = sel_we;
                    size_d  = sel_size;
                    addr_d  = sel_addr;
                    wdata_d = sel_wdata;
                    err_d   = sel_err;
                    if (sel_err) begin
                        upd_rdata = 1'b1;
                        state_d   = RESP;
                    end else begin
                        state_d = ACCESS;
                    end
                end
            end
            ACCESS: begin
                if (!we_q) begin
                    upd_rdata = 1'b1;
                    upd_val   = lane_extract(mem_dout, size_q, addr_q[1:0]);
                    state_d   = RESP;
                end else if (size_q == SZ_WORD) begin
                    upd_rdata = 1'b1;
                    state_d   = RESP;
                end else begin
                    merge_d = lane_merge(mem_dout, size_q, addr_q[1:0], wdata_q);
                    state_d = MERGE;
                end
            end
            MERGE: begin
                upd_rdata = 1'b1;
                state_d   = RESP;
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Store and error acks return zero; loads return the extracted lane.
        if (upd_rdata) begin
            if (owner_d) begin
                rdata1_d = upd_val;
            end else begin
                rdata0_d = upd_val;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            last_q   <= 1'b1;
            owner_q  <= 1'b0;
            we_q     <= 1'b0;
            size_q   <= 2'b00;
            addr_q   <= '0;
            wdata_q  <= 32'h0;
            err_q    <= 1'b0;
            merge_q  <= 32'h0;
            rdata0_q <= 32'h0;
            rdata1_q <= 32'h0;
        end else begin
            state_q  <= state_d;
            last_q   <= last_d;
            owner_q  <= owner_d;
            we_q     <= we_d;
            size_q   <= size_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            err_q    <= err_d;
            merge_q  <= merge_d;
            rdata0_q <= rdata0_d;
            rdata1_q <= rdata1_d;
        end
    end

    // Write strobe decodes straight from state so an async reset drops it at once.
    always_comb begin
        mem_we  = 1'b0;
        mem_din = 32'h0;
        if ((state_q == ACCESS) && we_q && (size_q == SZ_WORD)) begin
            mem_we  = 1'b1;
            mem_din = wdata_q;
        end else if (state_q == MERGE) begin
            mem_we  = 1'b1;
            mem_din = merge_q;
        end
    end

    assign mem_addr = {addr_q[ADDR_W-1:2], 2'b00};

    assign p0_ack   = (state_q == RESP) && !owner_q;
    assign p1_ack   = (state_q == RESP) &&  owner_q;
    assign p0_err   = p0_ack && err_q;
    assign p1_err   = p1_ack && err_q;
    assign p0_rdata = rdata0_q;
    assign p1_rdata = rdata1_q;

endmodule

// File: tb/tb_dm_arbiter.sv
// Bench for dm_arbiter: directed vector table, multi-cycle corner sequences,
// and a randomized two-port run against a byte-level transaction model.
module tb_dm_arbiter;
    localparam int MEM_BYTES = 12288;
    localparam int ADDR_W    = 14;
    localparam int NWORDS    = MEM_BYTES / 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              p0_req, p0_we, p1_req, p1_we;
    logic [1:0]        p0_size, p1_size;
    logic [ADDR_W-1:0] p0_addr, p1_addr;
    logic [31:0]       p0_wdata, p1_wdata;
    logic              p0_ack, p0_err, p1_ack, p1_err;
    logic [31:0]       p0_rdata, p1_rdata;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_din, mem_dout;
    logic              mem_we;

    int checks = 0;
    int failures = 0;

    dm_arbiter #(.MEM_BYTES(MEM_BYTES), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst(rst),
        .p0_req(p0_req), .p0_we(p0_we), .p0_size(p0_size), .p0_addr(p0_addr),
        .p0_wdata(p0_wdata), .p0_ack(p0_ack), .p0_rdata(p0_rdata), .p0_err(p0_err),
        .p1_req(p1_req), .p1_we(p1_we), .p1_size(p1_size), .p1_addr(p1_addr),
        .p1_wdata(p1_wdata), .p1_ack(p1_ack), .p1_rdata(p1_rdata), .p1_err(p1_err),
        .mem_addr(mem_addr), .mem_din(mem_din), .mem_we(mem_we), .mem_dout(mem_dout)
    );

    always #5 clk = ~clk;

    // Memory attached to the DUT
    logic [31:0] mem [0:NWORDS-1];
    logic        mem_clr = 1'b0;
    assign mem_dout = (int'(mem_addr[ADDR_W-1:2]) < NWORDS) ? mem[mem_addr[ADDR_W-1:2]] : 32'h0;
    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < NWORDS; i++) mem[i] <= 32'h0;
        end else if (mem_we && int'(mem_addr[ADDR_W-1:2]) < NWORDS) begin
            mem[mem_addr[ADDR_W-1:2]] <= mem_din;
        end
    end

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endfunction

    // ---------------- transaction-level reference model ----------------
    logic [7:0]  mb [0:MEM_BYTES-1];
    logic        model_en = 1'b0;
    int          m_cyc, m_free, m_ack, m_wecyc;
    logic        m_last, m_valid, m_port, m_err, m_load;
    logic [31:0] m_rdata;

    always @(posedge clk) begin
        int prev, nb, base, ai;
        logic w, we_l;
        logic [1:0] s;
        logic [31:0] wd;
        if (mem_clr) for (int i = 0; i < MEM_BYTES; i++) mb[i] = 8'h0;
        if (rst) begin
            m_cyc = 0; m_free = 0; m_last = 1'b1; m_valid = 1'b0;
        end else begin
            prev  = m_cyc;
            m_cyc = m_cyc + 1;
            if (model_en && prev >= m_free && (p0_req || p1_req)) begin
                if (p0_req && p1_req) w = (m_last == 1'b1) ? 1'b0 : 1'b1;
                else w = p1_req;
                m_last = w;
                s    = w ? p1_size : p0_size;
                ai   = int'(w ? p1_addr : p0_addr);
                wd   = w ? p1_wdata : p0_wdata;
                we_l = w ? p1_we : p0_we;
                nb   = (s == 2'b11) ? 4 : (1 << s);
                base = (ai / 4) * 4;
                m_err   = (s == 2'b11) || ((ai % nb) != 0) || (base > MEM_BYTES - 4);
                m_port  = w;
                m_load  = !we_l;
                m_valid = 1'b1;
                m_wecyc = -1;
                m_rdata = 32'h0;
                if (m_err) begin
                    m_ack = prev + 1;
                end else begin
                    if (we_l) begin
                        for (int i = 0; i < nb; i++) mb[ai + i] = wd[8*i +: 8];
                        m_wecyc = prev + ((s == 2'b10) ? 1 : 2);
                    end else begin
                        for (int i = 0; i < nb; i++) m_rdata[8*i +: 8] = mb[ai + i];
                    end
                    m_ack = prev + ((we_l && s != 2'b10) ? 3 : 2);
                end
                m_free = m_ack + 1;
            end
        end
    end

    always @(negedge clk) begin
        logic e0, e1, ew;
        if (model_en && !rst) begin
            e0 = m_valid && (m_ack == m_cyc) && !m_port;
            e1 = m_valid && (m_ack == m_cyc) &&  m_port;
            ew = m_valid && (m_wecyc == m_cyc);
            check($sformatf("rnd_p0_ack cyc%0d", m_cyc), {31'h0, p0_ack}, {31'h0, e0});
            check($sformatf("rnd_p1_ack cyc%0d", m_cyc), {31'h0, p1_ack}, {31'h0, e1});
            check($sformatf("rnd_mem_we cyc%0d", m_cyc), {31'h0, mem_we}, {31'h0, ew});
            if (e0 && p0_ack) begin
                check("rnd_p0_err", {31'h0, p0_err}, {31'h0, m_err});
                if (m_load && !m_err) check("rnd_p0_rdata", p0_rdata, m_rdata);
            end
            if (e1 && p1_ack) begin
                check("rnd_p1_err", {31'h0, p1_err}, {31'h0, m_err});
                if (m_load && !m_err) check("rnd_p1_rdata", p1_rdata, m_rdata);
            end
        end
    end

    // ---------------- directed vectors ----------------
    typedef struct {
        logic        port;
        logic        we;
        logic [1:0]  size;
        logic [13:0] addr;
        logic [31:0] wdata;
        logic        exp_err;
        logic [31:0] exp_rdata;
        int          exp_lat;
    } vec_t;

    vec_t vecs [20];

    task automatic drive(input logic port, input logic we, input logic [1:0] size,
                         input logic [13:0] addr, input logic [31:0] wdata);
        if (port) begin
            p1_req = 1'b1; p1_we = we; p1_size = size; p1_addr = addr; p1_wdata = wdata;
        end else begin
            p0_req = 1'b1; p0_we = we; p0_size = size; p0_addr = addr; p0_wdata = wdata;
        end
    endtask

    task automatic do_txn(input vec_t v, input string tag);
        int lat, we_cnt, other;
        logic got_err;
        logic [31:0] got_rd;
        lat = -1; we_cnt = 0; other = 0; got_err = 1'b0; got_rd = 32'h0;
        @(posedge clk); #1;
        drive(v.port, v.we, v.size, v.addr, v.wdata);
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (mem_we) we_cnt++;
            if (v.port ? p0_ack : p1_ack) other++;
            if (v.port ? p1_ack : p0_ack) begin
                lat = i;
                got_err = v.port ? p1_err : p0_err;
                got_rd  = v.port ? p1_rdata : p0_rdata;
                break;
            end
        end
        p0_req = 1'b0; p1_req = 1'b0;
        check({tag, "_lat"}, 32'(lat), 32'(v.exp_lat));
        check({tag, "_err"}, {31'h0, got_err}, {31'h0, v.exp_err});
        check({tag, "_we_pulses"}, 32'(we_cnt), (v.we && !v.exp_err) ? 32'd1 : 32'd0);
        check({tag, "_other_ack"}, 32'(other), 32'd0);
        if (!v.we && !v.exp_err) check({tag, "_rdata"}, got_rd, v.exp_rdata);
    endtask

    task automatic pulse_reset();
        @(negedge clk); rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk); rst = 1'b0;
    endtask

    task automatic new_req(input int port);
        logic [1:0] s;
        logic [13:0] a;
        int r;
        s = ($urandom_range(0, 15) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
        r = $urandom_range(0, 9);
        if (r == 0) a = 14'($urandom_range(12276, 16383));
        else a = 14'($urandom_range(0, 47));
        if (r < 6 && s != 2'b11) a = a & ~14'((1 << s) - 1);
        drive(port[0], 1'($urandom_range(0, 1)), s, a, $urandom);
    endtask

    task automatic rand_cycle(input logic gen_on, inout logic a0, inout logic a1);
        @(posedge clk); #1;
        if (!p0_req || a0) begin
            if (gen_on && $urandom_range(0, 3) != 0) new_req(0); else p0_req = 1'b0;
        end
        if (!p1_req || a1) begin
            if (gen_on && $urandom_range(0, 3) != 0) new_req(1); else p1_req = 1'b0;
        end
        @(negedge clk);
        a0 = p0_ack; a1 = p1_ack;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int nack, ack_cnt;
        int order [3];
        int when  [3];
        logic a0, a1;

        vecs[0]  = '{1'b0, 1'b1, 2'b10, 14'h0010, 32'hDEADBEEF, 1'b0, 32'h0, 2};
        vecs[1]  = '{1'b0, 1'b0, 2'b10, 14'h0010, 32'h0, 1'b0, 32'hDEADBEEF, 2};
        vecs[2]  = '{1'b1, 1'b1, 2'b00, 14'h0012, 32'h00000055, 1'b0, 32'h0, 3};
        vecs[3]  = '{1'b0, 1'b0, 2'b10, 14'h0010, 32'h0, 1'b0, 32'hDE55BEEF, 2};
        vecs[4]  = '{1'b1, 1'b1, 2'b01, 14'h0010, 32'h00001234, 1'b0, 32'h0, 3};
        vecs[5]  = '{1'b0, 1'b0, 2'b10, 14'h0010, 32'h0, 1'b0, 32'hDE551234, 2};
        vecs[6]  = '{1'b1, 1'b0, 2'b00, 14'h0013, 32'h0, 1'b0, 32'h000000DE, 2};
        vecs[7]  = '{1'b0, 1'b0, 2'b01, 14'h0012, 32'h0, 1'b0, 32'h0000DE55, 2};
        vecs[8]  = '{1'b0, 1'b0, 2'b10, 14'h0002, 32'h0, 1'b1, 32'h0, 1};
        vecs[9]  = '{1'b1, 1'b0, 2'b01, 14'h0011, 32'h0, 1'b1, 32'h0, 1};
        vecs[10] = '{1'b0, 1'b0, 2'b11, 14'h0010, 32'h0, 1'b1, 32'h0, 1};
        vecs[11] = '{1'b1, 1'b0, 2'b10, 14'h3000, 32'h0, 1'b1, 32'h0, 1};
        vecs[12] = '{1'b0, 1'b1, 2'b10, 14'h3000, 32'h00000001, 1'b1, 32'h0, 1};
        vecs[13] = '{1'b1, 1'b1, 2'b01, 14'h0011, 32'h0000FFFF, 1'b1, 32'h0, 1};
        vecs[14] = '{1'b0, 1'b1, 2'b10, 14'h2FFC, 32'hCAFEF00D, 1'b0, 32'h0, 2};
        vecs[15] = '{1'b1, 1'b0, 2'b10, 14'h2FFC, 32'h0, 1'b0, 32'hCAFEF00D, 2};
        vecs[16] = '{1'b0, 1'b1, 2'b00, 14'h2FFF, 32'h123456AB, 1'b0, 32'h0, 3};
        vecs[17] = '{1'b1, 1'b0, 2'b10, 14'h2FFC, 32'h0, 1'b0, 32'hABFEF00D, 2};
        vecs[18] = '{1'b0, 1'b0, 2'b10, 14'h0010, 32'h0, 1'b0, 32'hDE551234, 2};
        vecs[19] = '{1'b1, 1'b0, 2'b00, 14'h3000, 32'h0, 1'b1, 32'h0, 1};

        rst = 1'b1; mem_clr = 1'b1;
        p0_req = 0; p0_we = 0; p0_size = 0; p0_addr = 0; p0_wdata = 0;
        p1_req = 0; p1_we = 0; p1_size = 0; p1_addr = 0; p1_wdata = 0;
        @(posedge clk); @(posedge clk); mem_clr = 1'b0;
        @(negedge clk);
        check("rst_p0_ack", {31'h0, p0_ack}, 32'h0);
        check("rst_p1_ack", {31'h0, p1_ack}, 32'h0);
        check("rst_p0_err", {31'h0, p0_err}, 32'h0);
        check("rst_p1_err", {31'h0, p1_err}, 32'h0);
        check("rst_p0_rdata", p0_rdata, 32'h0);
        check("rst_p1_rdata", p1_rdata, 32'h0);
        check("rst_mem_we", {31'h0, mem_we}, 32'h0);
        check("rst_mem_addr", 32'(mem_addr), 32'h0);
        check("rst_mem_din", mem_din, 32'h0);
        rst = 1'b0;

        for (int k = 0; k < 20; k++) do_txn(vecs[k], $sformatf("vec%0d", k));

        // Simultaneous requests held high: p0, p1, p0 in acks at cycles 2, 5, 8.
        pulse_reset();
        for (int k = 0; k < 3; k++) begin order[k] = -1; when[k] = -1; end
        @(posedge clk); #1;
        drive(1'b0, 1'b0, 2'b10, 14'h0010, 32'h0);
        drive(1'b1, 1'b0, 2'b10, 14'h2FFC, 32'h0);
        nack = 0;
        for (int i = 0; i < 16 && nack < 3; i++) begin
            @(negedge clk);
            check("arb_one_owner", {31'h0, p0_ack & p1_ack}, 32'h0);
            if (p0_ack || p1_ack) begin
                order[nack] = p1_ack ? 1 : 0;
                when[nack]  = i;
                if (p0_ack) check("arb_p0_rdata", p0_rdata, 32'hDE551234);
                else        check("arb_p1_rdata", p1_rdata, 32'hABFEF00D);
                nack++;
            end
        end
        p0_req = 1'b0; p1_req = 1'b0;
        check("arb_ack_count", 32'(nack), 32'd3);
        check("arb_grant0", 32'(order[0]), 32'd0);
        check("arb_grant1", 32'(order[1]), 32'd1);
        check("arb_grant2", 32'(order[2]), 32'd0);
        check("arb_when0", 32'(when[0]), 32'd2);
        check("arb_when1", 32'(when[1]), 32'd5);
        check("arb_when2", 32'(when[2]), 32'd8);

        // Reset during MERGE of a byte store aborts it.
        @(posedge clk); #1;
        drive(1'b0, 1'b1, 2'b00, 14'h0011, 32'h00000099);
        @(negedge clk);
        @(negedge clk); check("mrst_access_we", {31'h0, mem_we}, 32'h0);
        @(negedge clk); check("mrst_merge_we", {31'h0, mem_we}, 32'h1);
        #1 rst = 1'b1;
        #1 check("mrst_we_async", {31'h0, mem_we}, 32'h0);
        check("mrst_ack_async", {31'h0, p0_ack}, 32'h0);
        p0_req = 1'b0;
        ack_cnt = 0;
        repeat (3) begin
            @(negedge clk);
            if (p0_ack || p1_ack || mem_we) ack_cnt++;
        end
        rst = 1'b0;
        check("mrst_quiet", 32'(ack_cnt), 32'd0);
        check("mrst_mem_word", mem[4], 32'hDE551234);
        do_txn('{1'b0, 1'b0, 2'b10, 14'h0010, 32'h0, 1'b0, 32'hDE551234, 2}, "mrst_next");

        // Request held through its ack runs twice.
        @(posedge clk); #1;
        drive(1'b0, 1'b0, 2'b10, 14'h2FFC, 32'h0);
        ack_cnt = 0;
        for (int i = 0; i < 11; i++) begin
            @(negedge clk);
            if (p0_ack) begin
                ack_cnt++;
                check("hold_rdata", p0_rdata, 32'hABFEF00D);
            end
            if (i == 6) p0_req = 1'b0;
        end
        check("hold_ack_count", 32'(ack_cnt), 32'd2);

        // Randomized two-port run against the model, from a cleared memory.
        @(negedge clk);
        rst = 1'b1; mem_clr = 1'b1; model_en = 1'b1;
        @(posedge clk); @(posedge clk); mem_clr = 1'b0;
        @(negedge clk); rst = 1'b0;
        a0 = 1'b0; a1 = 1'b0;
        for (int c = 0; c < 4000; c++) rand_cycle(1'b1, a0, a1);
        for (int c = 0; c < 40; c++) rand_cycle(1'b0, a0, a1);
        check("drain_reqs_done", {30'h0, p0_req, p1_req}, 32'h0);
        repeat (3) @(negedge clk);
        model_en = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dm_arbiter.md
Name: dm_arbiter

Overview:
- Shares the single-port 12 KB byte-addressed data memory (32-bit word read/write, little-endian, combinational read, write on rising clk) between two requesters: port 0 (CPU load/store unit) and port 1 (DMA/debug).
- Arbitrates round-robin and checks alignment and range.
- Turns byte and halfword stores into read-modify-write sequences, because the memory only writes full words.

Parameters:
- MEM_BYTES, 12288, memory size in bytes; a word access with base address > MEM_BYTES-4 is out of range.
- ADDR_W, 14, byte-address width.

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- pN_req  in  1  request; N = 0,1; held with its fields stable until pN_ack
- pN_we  in  1  1 = store, 0 = load
- pN_size  in  2  00 byte, 01 halfword, 10 word; 11 is illegal
- pN_addr  in  ADDR_W  byte address
- pN_wdata  in  32  store data, right-justified
- pN_ack  out  1  one-cycle completion pulse
- pN_rdata  out  32  load data, right-justified, zero-extended; valid while pN_ack=1
- pN_err  out  1  valid with pN_ack; misaligned, out-of-range or illegal size
- mem_addr  out  ADDR_W  word-aligned address to memory; low 2 bits always 0
- mem_din  out  32  write word
- mem_we  out  1  memory write enable
- mem_dout  in  32  memory read word (combinational)

Behaviour:
- Reset (async):
  - state=IDLE, last_grant=1, so port 0 wins the first tie.
  - All acks, errs, rdata = 0; mem_we=0 immediately; mem_addr=0; mem_din=0.
  - Reset mid-transaction aborts it: no ack, no write.
- State machine: IDLE, ACCESS, MERGE, RESP. Cycle n = state after rising edge n.
- IDLE:
  - Samples requests on the edge.
  - Only one port requesting: that port wins.
  - Both requesting: grant the port != last_grant, then last_grant <= winner.
  - Latch owner, we, size, addr, wdata.
  - Error check on the latched request:
    - size=11 is illegal.
    - Halfword with addr[0]=1 is misaligned.
    - Word with addr[1:0]!=0 is misaligned.
    - (addr & ~3) > MEM_BYTES-4 is out of range.
  - Error → RESP with err=1. Otherwise → ACCESS.
  - No request → stay in IDLE.
- ACCESS:
  - mem_addr = {addr[13:2],2'b00}.
  - Load: capture mem_dout, extract lane, → RESP.
    - Byte lane = addr[1:0]; halfword lane = addr[1].
  - Word store: mem_we=1, mem_din=wdata → RESP.
  - Byte/halfword store: mem_we=0, capture mem_dout into a merge register → MERGE.
- MERGE:
  - mem_we=1; mem_din = captured word with the target lane replaced by wdata[7:0] or wdata[15:0].
  - → RESP.
- RESP:
  - Owner's ack=1; rdata and err valid for this cycle. Other port's ack=0.
  - Requests are ignored. → IDLE.
  - rdata holds its value until the next ack to that port.
- Latency from the sampling edge to the ack cycle:
  - error: 1
  - load or word store: 2
  - sub-word store: 3
- Throughput: one transaction per 3–4 cycles, because IDLE costs a cycle.
- The requester must drop req, or present a new request, in the cycle after ack. A req still high in IDLE is treated as a new transaction.
- The losing port keeps req asserted and is served next. No starvation: the maximum wait is one full transaction of the other port.
- mem_we=1 only in ACCESS (word store) or MERGE. Errored requests never write memory.
- The non-owner port's request fields are never used.

Test Plan:
- Reset, then p0 word store addr 0x0010 data 0xDEADBEEF → mem_we pulse in cycle 1, p0_ack in cycle 2; then p0 word load 0x0010 → p0_rdata=0xDEADBEEF, err=0.
- After the above, p1 byte store addr 0x0012 data 0x55, then word load 0x0010 → 0xDE55BEEF. Halfword store 0x0010 data 0x1234 → word reads 0xDE551234. Byte load 0x0013 → 0x000000DE.
- p0 and p1 request simultaneously after reset, back-to-back, 3 rounds → grants p0, p1, p0; each ack only to its owner; no lost request.
- Errors: word load 0x0002, halfword 0x0011, size=11, and word 0x3000 (12288) → ack in cycle 1 with err=1, mem_we never high. Word 0x2FFC succeeds.
- Assert rst during MERGE of a byte store → mem_we drops asynchronously, no ack, memory word unchanged; next request is served normally starting from IDLE.
- Hold p0_req high through ack → a second identical transaction executes; verify ack count = 2.
